// File: rtl/callret_pkg.sv
// -----------------------------------------------------------------------------
// callret_pkg
// Shared definitions for the call/return sequencer (call_ret_ctrl):
//   - default widths and stack size
//   - return-address offset added to the caller PC
//   - sequencer state encoding (3-bit)
// -----------------------------------------------------------------------------
package callret_pkg;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_SP_W        = 8;
    localparam int DEF_STACK_DEPTH = 256;

    // Word-addressed PC: the return address is the next instruction word.
    localparam int DEF_RET_OFFSET  = 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PUSH = 3'd1,
        POP  = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_e;

endpackage

// File: rtl/callret_depth_ctr.sv
// -----------------------------------------------------------------------------
// callret_depth_ctr
// Up/down counter tracking how many entries the sequencer has on the stack.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   inc_i        count up (ignored when full)
//   dec_i        count down (ignored when empty)
//   clear_i      synchronous return to zero (highest priority)
//   cnt_o        current depth, SP_W+1 bits so a full stack is representable
//   full_o       registered: cnt_o == STACK_DEPTH
//   empty_o      registered: cnt_o == 0
// -----------------------------------------------------------------------------
module callret_depth_ctr
    import callret_pkg::*;
#(
    parameter int SP_W        = DEF_SP_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_i,
    input  logic          dec_i,
    input  logic          clear_i,
    output logic [SP_W:0] cnt_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam logic [SP_W:0] FULL_CNT = (SP_W + 1)'(STACK_DEPTH);
    localparam logic [SP_W:0] ONE_CNT  = (SP_W + 1)'(1);

    logic [SP_W:0] cnt_q;
    logic [SP_W:0] cnt_d;
    logic          full_q;
    logic          empty_q;

    // Next count: clear, then saturating increment / decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && !full_q) begin
            cnt_d = cnt_q + ONE_CNT;
        end else if (dec_i && !empty_q) begin
            cnt_d = cnt_q - ONE_CNT;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with full/empty flags derived from the next count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == FULL_CNT);
            empty_q <= (cnt_d == '0);
        end
    end

    assign cnt_o   = cnt_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/call_ret_ctrl.sv
// -----------------------------------------------------------------------------
// call_ret_ctrl
// Call/return sequencer in front of the stack memory. Converts CALL/RET
// requests into single-cycle push/pop strobes and returns the new PC to fetch.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   call_req, ret_req         requests, sampled only in IDLE (CALL has priority)
//   pc_in, target_in          caller PC and call target
//   err_clr                   synchronous clear of sticky error flags
//   busy, done, pc_load       status / completion / PC-load pulses
//   pc_out                    new PC (call target or popped return address)
//   stk_enable/push/pop       stack strobes, stk_data_in pushed data
//   stk_data_out, stk_empty   popped data (valid the cycle after pop), empty flag
//   depth                     number of stacked entries
//   overflow, underflow       sticky error flags
// Optional (macro CALLRET_SP_CHECK_EN):
//   stk_sp, sp_mismatch       stack-pointer cross-check, sticky mismatch flag
// All outputs are registered; strobes are decoded from the next state so they
// drop together with the state register on asynchronous reset.
// -----------------------------------------------------------------------------
module call_ret_ctrl
    import callret_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SP_W        = DEF_SP_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH,
    parameter int RET_OFFSET  = DEF_RET_OFFSET
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              call_req,
    input  logic              ret_req,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] target_in,
    input  logic              err_clr,
    output logic              busy,
    output logic              done,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_out,
    output logic              stk_enable,
    output logic              stk_push,
    output logic              stk_pop,
    output logic [DATA_W-1:0] stk_data_in,
    input  logic [DATA_W-1:0] stk_data_out,
    input  logic              stk_empty,
    output logic [SP_W:0]     depth,
    output logic              overflow,
    output logic              underflow
`ifdef CALLRET_SP_CHECK_EN
    ,
    input  logic [SP_W-1:0]   stk_sp,
    output logic              sp_mismatch
`endif
);

    localparam logic [DATA_W-1:0] RET_ADD = DATA_W'(RET_OFFSET);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] target_q, target_d;
    logic [DATA_W-1:0] pc_out_q, pc_out_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pc_load_q, pc_load_d;
    logic              push_q, push_d;
    logic              pop_q, pop_d;
    logic              en_q, en_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              cnt_inc;
    logic              cnt_dec;
    logic [SP_W:0]     depth_cnt;
    logic              depth_full;
    logic              depth_empty;

    callret_depth_ctr #(
        .SP_W        (SP_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_depth (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (cnt_inc),
        .dec_i   (cnt_dec),
        .clear_i (1'b0),
        .cnt_o   (depth_cnt),
        .full_o  (depth_full),
        .empty_o (depth_empty)
    );

    // Sequencer next state, datapath next values and next-cycle strobes.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        pc_out_d  = pc_out_q;
        data_in_d = '0;
        // A new error in the same cycle as err_clr overrides the clear below.
        ovf_d     = ovf_q & ~err_clr;
        unf_d     = unf_q & ~err_clr;
        cnt_inc   = 1'b0;
        cnt_dec   = 1'b0;

        case (state_q)
            IDLE: begin
                if (call_req) begin
                    target_d = target_in;
                    if (depth_full) begin
                        ovf_d   = 1'b1;
                        state_d = ERR;
                    end else begin
                        // Return address is formed at capture time so it is
                        // already registered on stk_data_in during PUSH.
                        data_in_d = pc_in + RET_ADD;
                        state_d   = PUSH;
                    end
                end else if (ret_req) begin
                    if (depth_empty || stk_empty) begin
                        unf_d   = 1'b1;
                        state_d = ERR;
                    end else begin
                        state_d = POP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            PUSH: begin
                cnt_inc  = 1'b1;
                pc_out_d = target_q;
                state_d  = DONE;
            end
            POP: begin
                cnt_dec = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                pc_out_d = stk_data_out;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d    = (state_d != IDLE);
        push_d    = (state_d == PUSH);
        pop_d     = (state_d == POP);
        en_d      = push_d | pop_d;
        done_d    = (state_d == DONE) || (state_d == ERR);
        pc_load_d = (state_d == DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            target_q  <= '0;
            pc_out_q  <= '0;
            data_in_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pc_load_q <= 1'b0;
            push_q    <= 1'b0;
            pop_q     <= 1'b0;
            en_q      <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            pc_out_q  <= pc_out_d;
            data_in_q <= data_in_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pc_load_q <= pc_load_d;
            push_q    <= push_d;
            pop_q     <= pop_d;
            en_q      <= en_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

`ifdef CALLRET_SP_CHECK_EN
    logic mis_q;
    logic mis_d;

    // Sticky flag: the stack's own pointer disagrees with our depth while idle.
    always_comb begin
        mis_d = (mis_q & ~err_clr) |
                ((state_q == IDLE) && (stk_sp != depth_cnt[SP_W-1:0]));
    end

    // Mismatch flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign sp_mismatch = mis_q;
`endif

    assign busy        = busy_q;
    assign done        = done_q;
    assign pc_load     = pc_load_q;
    assign pc_out      = pc_out_q;
    assign stk_enable  = en_q;
    assign stk_push    = push_q;
    assign stk_pop     = pop_q;
    assign stk_data_in = data_in_q;
    assign depth       = depth_cnt;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule

// File: doc/call_ret_ctrl.md
Name: call_ret_ctrl

Overview:
Call/return sequencer that sits directly upstream of the stack memory block (StackPointer). It converts CALL/RET requests from the control unit into single-cycle push/pop strobes on the stack, and hands the resulting PC back to the fetch stage. It also tracks stack depth and flags overflow and underflow.

Parameters:
DATA_W, 32, width of PC and stack data
SP_W, 8, width of the stack pointer and depth counter
STACK_DEPTH, 256, number of stack entries; the stack is full when depth == STACK_DEPTH
RET_OFFSET, 1, added to the caller PC to form the return address (word-addressed PC)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
call_req  in  1  CALL request, sampled only in IDLE
ret_req  in  1  RET request, sampled only in IDLE
pc_in  in  DATA_W  PC of the CALL instruction
target_in  in  DATA_W  CALL target address
err_clr  in  1  synchronous clear of the sticky error flags
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse (success or error)
pc_load  out  1  one-cycle pulse; pc_out valid, fetch must load it
pc_out  out  DATA_W  new PC (call target or popped return address)
stk_enable  out  1  stack enable
stk_push  out  1  stack push strobe
stk_pop  out  1  stack pop strobe
stk_data_in  out  DATA_W  data pushed to the stack
stk_data_out  in  DATA_W  popped data; valid the cycle after stk_pop
stk_empty  in  1  stack empty flag
depth  out  SP_W+1  current number of stacked entries
overflow  out  1  sticky: a CALL was attempted while the stack was full
underflow  out  1  sticky: a RET was attempted while the stack was empty

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs are 0: pc_out=0, depth=0, overflow=0, underflow=0, and all strobes 0. Reset mid-operation aborts the operation; no strobe may leak after rst falls.
- States and transitions:
  - IDLE: call_req has priority if call_req and ret_req are both high. On CALL, capture pc_in and target_in.
    - CALL with depth==STACK_DEPTH -> ERR, set overflow.
    - CALL otherwise -> PUSH.
    - RET with depth==0 or stk_empty=1 -> ERR, set underflow.
    - RET otherwise -> POP.
  - PUSH (1 cycle): stk_enable=1, stk_push=1, stk_data_in=pc_saved+RET_OFFSET (modulo 2^DATA_W, wraps silently). depth increments. pc_out<=target_saved. Next state DONE.
  - POP (1 cycle): stk_enable=1, stk_pop=1. depth decrements. Next state WAIT.
  - WAIT (1 cycle): pc_out<=stk_data_out. Next state DONE.
  - DONE (1 cycle): pc_load=1, done=1. Next state IDLE.
  - ERR (1 cycle): done=1, pc_load=0, pc_out unchanged, no stack strobes. Next state IDLE.
- Latency, with the request sampled at edge 0:
  - CALL: push strobe in cycle 1, pc_load in cycle 2.
  - RET: pop strobe in cycle 1, pc_load in cycle 3.
  - ERR: done in cycle 1.
- Requests arriving while busy=1 are ignored, not queued. The control unit holds off until done.
- stk_push and stk_pop are never high in the same cycle.
- stk_enable is high only in PUSH and POP.
- overflow and underflow remain set until reset or err_clr=1. If err_clr=1 and a new error occur in the same cycle, the set wins.

Optional Feature:
Macro CALLRET_SP_CHECK_EN.
- Defined: adds an input port stk_sp [SP_W-1:0] and an output port sp_mismatch (sticky, cleared by err_clr). In IDLE, each cycle, sp_mismatch is set if stk_sp != depth[SP_W-1:0].
- Undefined: neither port exists and no compare logic is generated.

Decomposition:
- Package callret_pkg holds:
  - the state encoding: IDLE, PUSH, POP, WAIT, DONE, ERR (3-bit)
  - DATA_W, SP_W and STACK_DEPTH defaults
  - the RET_OFFSET constant
- One sub-module, callret_depth_ctr: up/down counter with inc/dec/clear inputs and full/empty outputs. It is instantiated once.

Test Plan:
- Reset, then CALL with pc_in=32'h0000_0010, target_in=32'h0000_0100 -> stk_push for 1 cycle with stk_data_in=32'h0000_0011; 2 cycles after the request, pc_load=1 with pc_out=32'h0000_0100; depth=1.
- Continue from the previous scenario with RET, with the stack returning 32'h0000_0011 -> stk_pop for 1 cycle; pc_load 3 cycles after the request with pc_out=32'h0000_0011; depth=0.
- RET at depth 0 -> done pulses in cycle 1, underflow=1, no stk_pop, pc_load=0; after err_clr=1, underflow=0.
- 256 CALLs, then a 257th CALL -> overflow=1, no stk_push on the 257th, depth stays 256. Also CALL with pc_in=32'hFFFF_FFFF -> stk_data_in=32'h0000_0000.
- call_req and ret_req high together at depth 1 -> the CALL is performed (depth=2). A ret_req pulsed while busy -> ignored.
- rst driven low during the WAIT state of a RET -> state is IDLE immediately, pc_load is never asserted, depth=0, all flags 0.
